// File: rtl/offset_divider_pkg.sv
// -----------------------------------------------------------------------------
// offset_divider_pkg
//   Shared widths, state encoding and constants for the OffsetDivider
//   sequencer.
//   DIVIDEND_W : dividend / quotient width
//   DIVISOR_W  : divisor / remainder width (tied to the 10-bit LOD)
//   LOC_W      : width of the leading-one location code
// -----------------------------------------------------------------------------
package offset_divider_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 10;
  localparam int LOC_W      = 4;

  // Partial remainder carries one guard bit above the dividend.
  localparam int R_W   = DIVIDEND_W + 1;
  // Aligned divisor: divisor shifted up to the dividend MSB.
  localparam int D_W   = DIVIDEND_W + DIVISOR_W;
  // Iteration counter must hold DIVIDEND_W (the largest N).
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  // Location code reported by the LOD for an all-zero divisor.
  localparam logic [LOC_W-1:0] LOC_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ITER,
    DONE
  } state_e;

endpackage

// File: rtl/shortLeadingOneDetection.sv
// -----------------------------------------------------------------------------
// shortLeadingOneDetection
//   10-bit leading-one detector. Reports 0 for an all-zero input, otherwise
//   the index of the most significant set bit plus one (1..10).
//   in_i  : value to scan
//   loc_o : location code
// -----------------------------------------------------------------------------
module shortLeadingOneDetection (
  input  logic [9:0] in_i,
  output logic [3:0] loc_o
);

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block leaves it unassigned and a latch is never inferred.
  always_comb begin
    loc_o = 4'd0;
    // Ascending scan: the highest set bit is the last one to write loc_o.
    for (int i = 0; i < 10; i++) begin
      if (in_i[i]) loc_o = 4'(i + 1);
    end
  end

endmodule

// File: rtl/offset_divider_sequencer.sv
// -----------------------------------------------------------------------------
// offset_divider_sequencer
//   Iterative unsigned restoring divider. Accepts a dividend/divisor pair on a
//   valid/ready handshake, normalises the divisor with the leading-one
//   detector so that only the quotient bits that can be non-zero are
//   iterated, and returns quotient/remainder on a valid/ready handshake.
//   One operation in flight; latency accept-to-out_valid is 2+N cycles with
//   N = DIVIDEND_W+1-loc, or 2 cycles for a zero divisor.
//
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   in_valid     : operand valid
//   in_ready     : sequencer can accept operands (IDLE only)
//   dividend     : numerator
//   divisor      : denominator
//   out_valid    : result valid
//   out_ready    : consumer accepts result
//   quotient     : floor(dividend/divisor), all ones on divide-by-zero
//   remainder    : dividend mod divisor, zero on divide-by-zero
//   div_by_zero  : divisor was zero; qualified by out_valid
// -----------------------------------------------------------------------------
module offset_divider_sequencer
  import offset_divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  // Control and output registers
  state_e                state_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic                  dz_q;

  // Datapath registers
  logic [R_W-1:0]        r_q;
  logic [D_W-1:0]        d_q;
  logic [DIVIDEND_W-1:0] q_q;
  logic [DIVISOR_W-1:0]  divisor_q;
  logic [CNT_W-1:0]      n_q;

  // Combinational next values
  logic [LOC_W-1:0]      loc;
  logic                  r_ge_d;
  logic [R_W-1:0]        r_d;
  logic [DIVIDEND_W-1:0] q_d;
  logic [CNT_W-1:0]      shamt;
  logic [D_W-1:0]        d_init;
  logic [CNT_W-1:0]      n_init;
  logic                  accept;
  logic                  last_iter;

  shortLeadingOneDetection u_lod (
    .in_i  (divisor_q),
    .loc_o (loc)
  );

  assign accept    = in_valid && in_ready_q && (state_q == IDLE);
  assign last_iter = (n_q == CNT_W'(1));

  always_comb begin
    // One restoring step: subtract when the aligned divisor fits.
    r_ge_d = ({{(D_W - R_W){1'b0}}, r_q} >= d_q);
    // d_q never exceeds r_q when r_ge_d holds, so its upper bits are zero.
    r_d    = r_ge_d ? (r_q - d_q[R_W-1:0]) : r_q;
    q_d    = {q_q[DIVIDEND_W-2:0], r_ge_d};

    // Align the divisor MSB with dividend bit DIVIDEND_W-1. Quotient bits
    // above position DIVIDEND_W-loc are necessarily zero, so only
    // DIVIDEND_W+1-loc iterations are needed.
    shamt  = CNT_W'(DIVIDEND_W) - CNT_W'(loc);
    d_init = D_W'(divisor_q) << shamt;
    n_init = CNT_W'(DIVIDEND_W + 1) - CNT_W'(loc);
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            state_q    <= NORM;
          end
        end

        NORM: begin
          if (loc == LOC_ZERO) begin
            quotient_q  <= '1;
            remainder_q <= '0;
            dz_q        <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q <= ITER;
          end
        end

        ITER: begin
          if (last_iter) begin
            quotient_q  <= q_d;
            remainder_q <= r_d[DIVISOR_W-1:0];
            dz_q        <= 1'b0;
            state_q     <= DONE;
          end
        end

        DONE: begin
          // out_valid rises one cycle after entering DONE and holds until
          // the consumer pops; in_ready returns only after the pop edge.
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the datapath registers are not reset: every field is loaded on
  // accept or in NORM before it is read, so a reset would only add routing.
  always_ff @(posedge clk) begin
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          r_q       <= R_W'(dividend);
          divisor_q <= divisor;
          q_q       <= '0;
        end
      end

      NORM: begin
        d_q <= d_init;
        n_q <= n_init;
      end

      ITER: begin
        r_q <= r_d;
        q_q <= q_d;
        d_q <= d_q >> 1;
        n_q <= n_q - CNT_W'(1);
      end

      default: ;
    endcase
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_offset_divider_sequencer.sv
// -----------------------------------------------------------------------------
// tb_offset_divider_sequencer
//   Directed and random stimulus for offset_divider_sequencer. A scoreboard
//   process predicts each result with plain integer division and checks every
//   out_valid cycle; directed operations additionally pin hand-computed values.
// -----------------------------------------------------------------------------
module tb_offset_divider_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [9:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [9:0]  remainder;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] q;
    logic [9:0]  r;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  offset_divider_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: arithmetic division; latency from the bit length of the divisor.
  function automatic exp_t model(input logic [15:0] a, input logic [9:0] b, input int acc);
    exp_t e;
    int   bits = 0;
    int   x    = int'(b);
    while (x != 0) begin
      bits++;
      x = x >> 1;
    end
    e.acc = acc;
    if (b == 10'd0) begin
      e.q   = 16'hFFFF;
      e.r   = 10'd0;
      e.dz  = 1'b1;
      e.lat = 2;
    end else begin
      e.q   = 16'(int'(a) / int'(b));
      e.r   = 10'(int'(a) % int'(b));
      e.dz  = 1'b0;
      e.lat = 2 + (17 - bits);
    end
    return e;
  endfunction

  // Scoreboard: predict on accept, compare on every out_valid cycle.
  initial begin
    bit first = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        first = 1'b1;
      end else begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            if (first) begin
              check("sb_latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
              first = 1'b0;
            end
            check("sb_quotient", 32'(quotient), 32'(sb[0].q));
            check("sb_remainder", 32'(remainder), 32'(sb[0].r));
            check("sb_div_by_zero", 32'(div_by_zero), 32'(sb[0].dz));
            check("sb_in_ready_busy", 32'(in_ready), 32'd0);
            if (out_ready) begin
              void'(sb.pop_front());
              first = 1'b1;
            end
          end
        end
        if (in_valid && in_ready) sb.push_back(model(dividend, divisor, cyc + 1));
      end
    end
  end

  // Present operands until accepted; returns #1 after the accept edge.
  task automatic send(input logic [15:0] a, input logic [9:0] b);
    int t = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        $display("FAIL send_timeout: got in_ready 0 expected 1");
        $fatal(1, "in_ready never rose");
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Junk on the operand ports must not disturb the running operation.
    dividend = 16'($urandom);
    divisor  = 10'($urandom);
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    forever begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
      if (lat > 100) begin
        $display("FAIL wait_valid_timeout: got out_valid 0 expected 1");
        $fatal(1, "out_valid never rose");
      end
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [9:0] b,
                        input logic [15:0] eq, input logic [9:0] er,
                        input logic edz, input int elat, input string tag);
    int lat;
    send(a, b);
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_quotient"}, 32'(quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(remainder), 32'(er));
    check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(edz));
  endtask

  initial begin
    int  lat;
    bit  seen;
    logic [15:0] ra;
    logic [9:0]  rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results.
    run_op(16'd1000,  10'd7,    16'd142,   10'd6,  1'b0, 16, "d1000_7");
    run_op(16'd65535, 10'd1,    16'd65535, 10'd0,  1'b0, 18, "d65535_1");
    run_op(16'd65535, 10'd1023, 16'd64,    10'd63, 1'b0, 9,  "d65535_1023");
    run_op(16'd1234,  10'd0,    16'hFFFF,  10'd0,  1'b1, 2,  "d1234_0");
    run_op(16'd10,    10'd3,    16'd3,     10'd1,  1'b0, 17, "d10_3");
    run_op(16'd0,     10'd512,  16'd0,     10'd0,  1'b0, 9,  "d0_512");

    // Back-pressure: result held, new operands ignored until the pop.
    send(16'd500, 10'd20);
    out_ready = 1'b0;
    wait_valid(lat);
    check("hold_latency", 32'(lat), 32'd14);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = 16'd7;
      divisor  = 10'd7;
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_quotient", 32'(quotient), 32'd25);
      check("hold_remainder", 32'(remainder), 32'd0);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("pop_out_valid_drop", 32'(out_valid), 32'd0);
    check("pop_in_ready_rise", 32'(in_ready), 32'd1);
    run_op(16'd7, 10'd7, 16'd1, 10'd0, 1'b0, 16, "d7_7");

    // Reset in the middle of an iteration discards the operation.
    send(16'd40000, 10'd9);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_div_by_zero", 32'(div_by_zero), 32'd0);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_output", 32'(seen), 32'd0);
    run_op(16'd40000, 10'd9, 16'd4444, 10'd4, 1'b0, 15, "d40000_9");

    // Random operands, checked by the scoreboard.
    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 10'd0;
        1:       rb = 10'($urandom_range(1, 3));
        2:       rb = 10'($urandom_range(512, 1023));
        default: rb = 10'($urandom_range(0, 1023));
      endcase
      send(ra, rb);
      wait_valid(lat);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
